// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame controller.
// State encoding and TX line mux selections.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_DATA  = 2'b01;
  localparam logic [1:0] MUX_PAR   = 2'b10;
  localparam logic [1:0] MUX_STOP  = 2'b11;

  // Line select for a given state; idle and stop both hold the line high.
  function automatic logic [1:0] state_mux_sel(input state_e st);
    logic [1:0] sel;
    sel = MUX_STOP;
    unique case (st)
      StStart:  sel = MUX_START;
      StData:   sel = MUX_DATA;
      StParity: sel = MUX_PAR;
      default:  sel = MUX_STOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_bit_cnt.sv
// Data-bit counter for the UART transmit controller.
// Synchronous clear has priority over enable; tc flags the last data bit.
module uart_tx_bit_cnt
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          en,
  output logic [$clog2(DATA_WIDTH)-1:0] cnt,
  output logic                          tc
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] Last = CntW'(DATA_WIDTH - 1);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == Last);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, data, optional parity and stop phases.
// Define UART_TX_TWO_STOP_EN to add the STOP2 input and a two-cycle stop phase.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          Data_Valid,
  input  logic                          PAR_EN,
`ifdef UART_TX_TWO_STOP_EN
  input  logic                          STOP2,
`endif
  output logic                          ser_load,
  output logic                          ser_en,
  output logic                          par_en_q,
  output logic [1:0]                    mux_sel,
  output logic                          busy,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_idx
);

  state_e state_q, state_d;
  logic   stop_last;
  logic   cnt_en, cnt_clr, cnt_tc;

`ifdef UART_TX_TWO_STOP_EN
  logic stop2_q;
  logic stop_cnt_q;
  // With two stop bits, only the second stop cycle may accept a new frame.
  assign stop_last = ~stop2_q | stop_cnt_q;
`else
  assign stop_last = 1'b1;
`endif

  assign ser_load = Data_Valid & ((state_q == StIdle) | ((state_q == StStop) & stop_last));

  assign cnt_en  = (state_q == StData);
  assign cnt_clr = reset | (cnt_en & cnt_tc);

  uart_tx_bit_cnt #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bit_cnt (
    .clk(clk),
    .clr(cnt_clr),
    .en (cnt_en),
    .cnt(bit_idx),
    .tc (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (ser_load) state_d = StStart;
      StStart:  state_d = StData;
      StData:   if (cnt_tc) state_d = par_en_q ? StParity : StStop;
      StParity: state_d = StStop;
      StStop: begin
        if (ser_load) begin
          state_d = StStart;
        end else if (stop_last) begin
          state_d = StIdle;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      busy     <= 1'b0;
      ser_en   <= 1'b0;
      mux_sel  <= MUX_STOP;
      par_en_q <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy    <= (state_d != StIdle);
      ser_en  <= (state_d == StData);
      mux_sel <= state_mux_sel(state_d);
      if (ser_load) begin
        par_en_q <= PAR_EN;
      end
`ifdef UART_TX_TWO_STOP_EN
      if (ser_load) begin
        stop2_q <= STOP2;
      end
      stop_cnt_q <= (state_q == StStop) & ~stop_last;
`endif
    end
  end

endmodule
